// File: rtl/io_channel_scheduler_pkg.sv
// io_channel_pkg: shared state and request encodings for the channel scheduler
package io_channel_pkg;
  typedef enum logic [1:0] {LOAD, RUN, DRAIN, DONE} state_e;
  typedef enum logic [1:0] {REQ_NONE, REQ_IN_SIZE, REQ_IN, REQ_OUT} req_e;
endpackage

// File: rtl/io_channel_scheduler_if.sv
// io_channel_scheduler_if: host load/drain and executor request/response bundle
interface io_channel_scheduler_if #(parameter int W = 12);
  logic         loadValid;
  logic [W-1:0] loadData;
  logic         loadReady;
  logic         loadDone;
  logic [1:0]   req;
  logic [W-1:0] reqData;
  logic         progDone;
  logic         respValid;
  logic [W-1:0] respData;
  logic         respEmpty;
  logic         drainValid;
  logic [W-1:0] drainData;
  logic         drainReady;
  logic         done;
  logic         outWrapped;
  logic         protocolError;
  modport master (
    output loadValid, loadData, loadDone, req, reqData, progDone, drainReady,
    input  loadReady, respValid, respData, respEmpty, drainValid, drainData, done, outWrapped, protocolError
  );
  modport slave (
    input  loadValid, loadData, loadDone, req, reqData, progDone, drainReady,
    output loadReady, respValid, respData, respEmpty, drainValid, drainData, done, outWrapped, protocolError
  );
endinterface

// File: rtl/io_channel_scheduler_ram.sv
// channel_ram: simple dual-port memory, one write port and one synchronous read port
module channel_ram #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 12,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  assign rdata = rdata_q;
  // write port plus registered read; contents need no reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end
endmodule

// File: rtl/io_channel_scheduler.sv
// io_channel_scheduler: sequences LOAD/RUN/DRAIN of the executor's input and output channels
module io_channel_scheduler
  import io_channel_pkg::*;
#(
  parameter int MemoryElementWidth = 12,
  parameter int NIn = 2,
  parameter int NOut = 2000
) (
  input logic clock,
  input logic reset,
  io_channel_scheduler_if.slave bus
);
  localparam int W = MemoryElementWidth;
  localparam int ICW = $clog2(NIn + 1);
  localparam int OCW = $clog2(NOut + 1);
  localparam int IAW = NIn > 1 ? $clog2(NIn) : 1;
  localparam int OAW = $clog2(NOut);
  localparam logic [ICW-1:0] NIN_C = ICW'(NIn);
  localparam logic [OCW-1:0] NOUT_C = OCW'(NOut);
  localparam logic [OAW-1:0] OLAST = OAW'(NOut - 1);
  state_e state_q, state_d;
  logic live_q, live_d;
  logic [ICW-1:0] load_cnt_q, load_cnt_d, in_pos_q, in_pos_d;
  logic [OAW-1:0] out_pos_q, out_pos_d, rd_ptr_q, rd_ptr_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d, drain_left_q, drain_left_d;
  logic resp_valid_q, resp_valid_d, resp_empty_q, resp_empty_d, resp_ram_q, resp_ram_d;
  logic [W-1:0] resp_word_q, resp_word_d;
  logic drain_valid_q, drain_valid_d, wrapped_q, wrapped_d, perr_q, perr_d;
  logic load_fire, in_hit, out_we, drain_fire;
  logic [W-1:0] in_rdata, out_rdata;
  assign bus.loadReady = live_q && state_q == LOAD && load_cnt_q < NIN_C;
  assign bus.respValid = resp_valid_q;
  assign bus.respData = resp_ram_q ? in_rdata : resp_word_q;
  assign bus.respEmpty = resp_empty_q;
  assign bus.drainValid = drain_valid_q;
  assign bus.drainData = drain_valid_q ? out_rdata : '0;
  assign bus.done = state_q == DONE;
  assign bus.outWrapped = wrapped_q;
  assign bus.protocolError = perr_q;
  assign live_d = 1'b1;
  channel_ram #(.DEPTH(NIn), .WIDTH(W)) u_in_ram (
    .clk(clock), .we(load_fire), .waddr(load_cnt_q[IAW-1:0]), .wdata(bus.loadData),
    .raddr(in_pos_q[IAW-1:0]), .rdata(in_rdata)
  );
  channel_ram #(.DEPTH(NOut), .WIDTH(W)) u_out_ram (
    .clk(clock), .we(out_we), .waddr(out_pos_q), .wdata(bus.reqData),
    .raddr(rd_ptr_d), .rdata(out_rdata)
  );
  // next state, channel pointers, response word and drain prefetch pointer
  always_comb begin
    load_fire = bus.loadReady && bus.loadValid;
    in_hit = in_pos_q < load_cnt_q;
    out_we = state_q == RUN && bus.req == REQ_OUT;
    drain_fire = drain_valid_q && bus.drainReady;
    state_d = state_q;
    load_cnt_d = load_cnt_q + ICW'(load_fire);
    in_pos_d = in_pos_q;
    out_pos_d = out_pos_q;
    out_cnt_d = out_cnt_q;
    rd_ptr_d = rd_ptr_q;
    drain_left_d = drain_left_q;
    resp_valid_d = state_q == RUN && bus.req != REQ_NONE;
    resp_empty_d = 1'b0;
    resp_ram_d = 1'b0;
    resp_word_d = '0;
    drain_valid_d = 1'b0;
    wrapped_d = wrapped_q || (out_we && out_cnt_q == NOUT_C);
    perr_d = perr_q || (bus.req != REQ_NONE && state_q != RUN) || (bus.loadDone && state_q != LOAD)
             || (bus.progDone && state_q != RUN);
    case (state_q)
      LOAD: state_d = bus.loadDone ? RUN : LOAD;
      RUN: begin
        if (bus.req == REQ_IN_SIZE) resp_word_d = W'(load_cnt_q - in_pos_q);
        if (bus.req == REQ_IN) begin
          resp_ram_d = in_hit;
          resp_empty_d = !in_hit;
          in_pos_d = in_pos_q + ICW'(in_hit);
        end
        if (out_we) begin
          resp_word_d = bus.reqData;
          out_pos_d = out_pos_q == OLAST ? '0 : out_pos_q + 1'b1;
          out_cnt_d = out_cnt_q + OCW'(out_cnt_q != NOUT_C);
        end
        if (bus.progDone) begin
          state_d = out_cnt_d == '0 ? DONE : DRAIN;
          rd_ptr_d = out_cnt_d == NOUT_C ? out_pos_d : '0;
          drain_left_d = out_cnt_d;
        end
      end
      DRAIN: begin
        rd_ptr_d = drain_fire ? (rd_ptr_q == OLAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        drain_left_d = drain_left_q - OCW'(drain_fire);
        drain_valid_d = drain_left_d != '0;
        state_d = drain_left_d == '0 ? DONE : DRAIN;
      end
      default: ;
    endcase
  end
  // state and counter registers, all cleared by the asynchronous reset
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= LOAD;
      live_q <= 1'b0;
      load_cnt_q <= '0;
      in_pos_q <= '0;
      out_pos_q <= '0;
      out_cnt_q <= '0;
      rd_ptr_q <= '0;
      drain_left_q <= '0;
      resp_valid_q <= 1'b0;
      resp_empty_q <= 1'b0;
      resp_ram_q <= 1'b0;
      resp_word_q <= '0;
      drain_valid_q <= 1'b0;
      wrapped_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q <= live_d;
      load_cnt_q <= load_cnt_d;
      in_pos_q <= in_pos_d;
      out_pos_q <= out_pos_d;
      out_cnt_q <= out_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      drain_left_q <= drain_left_d;
      resp_valid_q <= resp_valid_d;
      resp_empty_q <= resp_empty_d;
      resp_ram_q <= resp_ram_d;
      resp_word_q <= resp_word_d;
      drain_valid_q <= drain_valid_d;
      wrapped_q <= wrapped_d;
      perr_q <= perr_d;
    end
endmodule
